demod_reg_bank: RTL
===================

# demod_reg_bank

Parametrised demodulator control/status register bank on the bus-clock domain; the next generation of the demod register block. Provides byte-lane writable control registers, an N-channel DAC select register, atomically-updated false-lock parameters, synchronised live status, sticky write-one-to-clear lock-loss flags with an interrupt, and optional saturating lock-loss event counters. Sits between the host bus decoder and the demod datapath.

## Interface
- NUM_DACS, 3, number of DAC select fields, 1..4
- NUM_STATUS, 4, number of lock/status inputs, 1..4
- CNT_W, 8, lock-loss counter width, 1..8

- busClk  in  1  bus clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cs  in  1  block select
- wr0..wr3  in  1 each  byte-lane write strobes (dataIn[7:0]..[31:24]), sampled with cs
- rd  in  1  read strobe, sampled with cs
- addr  in  13  word address; addr[4:2] selects register, upper bits ignored
- dataIn  in  32  write data
- dataOut  out  32  registered read data
- statusIn  in  NUM_STATUS  lock inputs, asynchronous to busClk (bit0 demodLock, bit1 bitsyncLock, bit2 highFreqOffset, bit3 auBitsyncLock)
- fskDeviation  in  16  live deviation estimate
- demodMode  out  5  demod mode
- oqpskIthenQ  out  1  OQPSK ordering
- dacSelect  out  4*NUM_DACS  field k at [4k+3:4k]
- falseLockAlpha  out  16
- falseLockThreshold  out  16
- amTC  out  5
- lossIrq  out  1  registered OR of (sticky & irqMask)

## Operation
- Register map (addr[4:2]): 0 CONTROL {irqMask[27:24] (bits ≥ NUM_STATUS read 0), oqpskIthenQ[13], demodMode[4:0]}; 1 DACSELECT field k at dataIn[8k+3:8k]; 2 FALSELOCK {threshold[31:16], alpha[15:0]}; 3 STATUS live synchronised statusIn in [NUM_STATUS-1:0], RO; 4 AMTC [4:0]; 5 FSKDEV {16'b0, fskDeviation}, RO; 6 STICKY [NUM_STATUS-1:0], W1C; 7 LOSSCOUNT counter i at [8i+CNT_W-1:8i], RO, clear-on-read.
- Writes: a field updates when cs & wr<lane> & the lane containing it is asserted; unmapped/reserved bits ignored, read 0.
- FALSELOCK atomicity: byte writes land in a 32-bit shadow; falseLockAlpha/Threshold load from shadow (including bytes written in the same access) only on the cycle after a cs & wr3 write to FALSELOCK. Reads of FALSELOCK return the shadow.
- Status path: each statusIn bit passes a 2-flop synchroniser, then a 1-flop delay for edge detection. Falling edge (1→0) of synchronised bit i = lock-loss event i.
- Sticky: event i sets sticky[i]; write of 1 to bit i of STICKY clears it; event and clear in same cycle → stays set.
- Counters: event i increments counter i, saturating at all-ones. cs & rd at LOSSCOUNT clears all counters; increment in the same cycle → counter = 1 for that channel.
- Reads: cs & rd captures selected register into dataOut at next edge; otherwise dataOut holds. Simultaneous cs & rd & wr to same register returns pre-write value.

## Timing
- Reset values: demodMode 0, oqpskIthenQ 0, irqMask 0, dacSelect field k = k, falseLockAlpha 0x0000, falseLockThreshold 0xFFFF, shadow = {0xFFFF,0x0000}, amTC 0, sticky 0, counters 0, synchronisers 0, dataOut 0, lossIrq 0.
- Synchronisers reset to 0, so no event fires on exit from reset.
- Control writes: output valid 1 cycle after strobe edge. FALSELOCK outputs: 2 cycles after wr3 edge.
- Read latency 1 cycle. statusIn fall → sticky/counter update 3 cycles; lossIrq 1 cycle after sticky.
- Reset mid-operation clears everything, including pending shadow commit.

## Configuration
- DEMOD_LOSS_COUNTERS_EN defined: counters and clear-on-read as above.
- Undefined: no counters; LOSSCOUNT reads 0; reads have no side effects; sticky/IRQ unchanged.

## Test plan
- Reset, read all 8 registers → CONTROL 0, DACSELECT 0x00020100 (NUM_DACS=3), FALSELOCK 0xFFFF0000, STICKY 0, LOSSCOUNT 0; lossIrq 0.
- Write FALSELOCK 0x12345678 with wr0 only, then wr1|wr2|wr3 → outputs unchanged after first access; alpha 0x5678, threshold 0x1234 two cycles after second.
- irqMask=0x1, drop statusIn[0] → sticky=0x1 after 3 cycles, lossIrq=1 next cycle; W1C 0x1 → lossIrq 0; repeat with fall coinciding with W1C → sticky stays 1.
- Pulse statusIn[1] low 300 times (CNT_W=8) → LOSSCOUNT[15:8]=0xFF; read again → 0x00.
- Read LOSSCOUNT in same cycle as an event on bit 0 → returns prior count, counter 0 becomes 1.
- Build without DEMOD_LOSS_COUNTERS_EN, 5 events → LOSSCOUNT reads 0, sticky still set.

Source files
------------

// File: rtl/demod_reg_bank_if.sv
// Host-side register bus for demod_reg_bank: select, byte-lane write strobes,
// read strobe, word address and data in both directions.
interface demod_reg_bank_if;
  logic        cs;
  logic        wr0;
  logic        wr1;
  logic        wr2;
  logic        wr3;
  logic        rd;
  logic [12:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  modport master (output cs, wr0, wr1, wr2, wr3, rd, addr, dataIn, input dataOut);
  modport slave  (input cs, wr0, wr1, wr2, wr3, rd, addr, dataIn, output dataOut);
endinterface

// File: rtl/demod_reg_bank.sv
// Demod control/status register bank on the bus clock. Optional saturating
// lock-loss event counters are built only when DEMOD_LOSS_COUNTERS_EN is defined.
module demod_reg_bank #(
  parameter int NUM_DACS   = 3,
  parameter int NUM_STATUS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    busClk,
  input  logic                    reset,
  demod_reg_bank_if.slave         bus,
  input  logic [NUM_STATUS-1:0]   statusIn_i,
  input  logic [15:0]             fskDeviation_i,
  output logic [4:0]              demodMode_o,
  output logic                    oqpskIthenQ_o,
  output logic [4*NUM_DACS-1:0]   dacSelect_o,
  output logic [15:0]             falseLockAlpha_o,
  output logic [15:0]             falseLockThreshold_o,
  output logic [4:0]              amTC_o,
  output logic                    lossIrq_o
);
  localparam logic [2:0] A_CONTROL = 3'd0;
  localparam logic [2:0] A_DACSEL  = 3'd1;
  localparam logic [2:0] A_FLOCK   = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_AMTC    = 3'd4;
  localparam logic [2:0] A_FSKDEV  = 3'd5;
  localparam logic [2:0] A_STICKY  = 3'd6;
  localparam logic [2:0] A_LOSSCNT = 3'd7;

  logic [2:0] sel;
  logic [3:0] we;
  logic       unused_addr;
  assign sel         = bus.addr[4:2];
  assign we          = {4{bus.cs}} & {bus.wr3, bus.wr2, bus.wr1, bus.wr0};
  assign unused_addr = ^{bus.addr[12:5], bus.addr[1:0]};

  logic [4:0]            demod_mode_q;
  logic                  oqpsk_q;
  logic [NUM_STATUS-1:0] irq_mask_q;
  logic [4*NUM_DACS-1:0] dac_sel_q;
  logic [31:0]           shadow_q;
  logic [15:0]           alpha_q;
  logic [15:0]           thr_q;
  logic                  commit_q;
  logic [4:0]            amtc_q;

  always_ff @(posedge busClk) begin
    if (reset) begin
      demod_mode_q <= '0;
      oqpsk_q      <= 1'b0;
      irq_mask_q   <= '0;
      for (int k = 0; k < NUM_DACS; k++) dac_sel_q[4*k +: 4] <= 4'(k);
      shadow_q     <= 32'hFFFF_0000;
      alpha_q      <= 16'h0000;
      thr_q        <= 16'hFFFF;
      commit_q     <= 1'b0;
      amtc_q       <= '0;
    end else begin
      if (sel == A_CONTROL) begin
        if (we[0]) demod_mode_q <= bus.dataIn[4:0];
        if (we[1]) oqpsk_q      <= bus.dataIn[13];
        if (we[3]) irq_mask_q   <= bus.dataIn[24 +: NUM_STATUS];
      end
      if (sel == A_DACSEL) begin
        for (int k = 0; k < NUM_DACS; k++)
          if (we[k]) dac_sel_q[4*k +: 4] <= bus.dataIn[8*k +: 4];
      end
      if (sel == A_FLOCK) begin
        for (int b = 0; b < 4; b++)
          if (we[b]) shadow_q[8*b +: 8] <= bus.dataIn[8*b +: 8];
      end
      // Commit one cycle late so bytes written alongside wr3 are already in the shadow.
      commit_q <= (sel == A_FLOCK) && we[3];
      if (commit_q) begin
        alpha_q <= shadow_q[15:0];
        thr_q   <= shadow_q[31:16];
      end
      if (sel == A_AMTC && we[0]) amtc_q <= bus.dataIn[4:0];
    end
  end

  logic [NUM_STATUS-1:0] sync1_q, sync2_q, dly_q;
  logic [NUM_STATUS-1:0] loss_evt;
  logic [NUM_STATUS-1:0] sticky_q, sticky_d, w1c;
  logic                  irq_q;

  assign loss_evt = dly_q & ~sync2_q;
  assign w1c      = (sel == A_STICKY && we[0]) ? bus.dataIn[NUM_STATUS-1:0] : '0;
  assign sticky_d = (sticky_q & ~w1c) | loss_evt;

  always_ff @(posedge busClk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      dly_q    <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= statusIn_i;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      sticky_q <= sticky_d;
      irq_q    <= |(sticky_q & irq_mask_q);
    end
  end

  logic [31:0] loss_count;
`ifdef DEMOD_LOSS_COUNTERS_EN
  logic [NUM_STATUS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                             cnt_clr;
  assign cnt_clr = bus.cs & bus.rd & (sel == A_LOSSCNT);

  // A clear coinciding with an event leaves that event counted.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (cnt_clr)
        cnt_d[i] = CNT_W'(loss_evt[i]);
      else if (loss_evt[i] && cnt_q[i] != {CNT_W{1'b1}})
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge busClk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    loss_count = '0;
    for (int i = 0; i < NUM_STATUS; i++) loss_count[8*i +: CNT_W] = cnt_q[i];
  end
`else
  assign loss_count = '0;
`endif

  logic [31:0] rdata_d, dout_q;
  always_comb begin
    rdata_d = '0;
    case (sel)
      A_CONTROL: begin
        rdata_d[4:0]              = demod_mode_q;
        rdata_d[13]               = oqpsk_q;
        rdata_d[24 +: NUM_STATUS] = irq_mask_q;
      end
      A_DACSEL: for (int k = 0; k < NUM_DACS; k++) rdata_d[8*k +: 4] = dac_sel_q[4*k +: 4];
      A_FLOCK:   rdata_d = shadow_q;
      A_STATUS:  rdata_d[NUM_STATUS-1:0] = sync2_q;
      A_AMTC:    rdata_d[4:0] = amtc_q;
      A_FSKDEV:  rdata_d[15:0] = fskDeviation_i;
      A_STICKY:  rdata_d[NUM_STATUS-1:0] = sticky_q;
      A_LOSSCNT: rdata_d = loss_count;
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge busClk) begin
    if (reset)                dout_q <= '0;
    else if (bus.cs & bus.rd) dout_q <= rdata_d;
  end

  assign bus.dataOut          = dout_q;
  assign demodMode_o          = demod_mode_q;
  assign oqpskIthenQ_o        = oqpsk_q;
  assign dacSelect_o          = dac_sel_q;
  assign falseLockAlpha_o     = alpha_q;
  assign falseLockThreshold_o = thr_q;
  assign amTC_o               = amtc_q;
  assign lossIrq_o            = irq_q;
endmodule
